axi_line_master: RTL
====================

Name: axi_line_master

Overview:
- AXI4 manager that turns single cache-line requests from the L1 cache/refill logic into INCR bursts toward the DRAM satellite on the AXI mux.
- Read request: issues AR, collects BEATS words from R, returns the line.
- Write request (writeback): issues AW, streams BEATS words on W, waits for B.
- One transaction outstanding at a time; it sits between the cache controller and axi_bus_if on the manager side of the mux.

Parameters:
- BEATS, 4, words per line / burst length; power of two, 2..16
- AXI_ID, 4'h0, constant value driven on awid/arid
- LINE_W, BEATS*32, derived line width in bits

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  line request offered
- req_ready  out  1  block idle and accepting a request
- req_write  in  1  1 = writeback, 0 = fill
- req_addr  in  32  byte address; the low log2(BEATS*4) bits are ignored
- req_wdata  in  LINE_W  writeback line; word 0 is in the LSBs
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  LINE_W  fill data, valid while resp_valid
- resp_err  out  1  error flag, valid while resp_valid
- abif  axi_bus_if manager-side modport (controller_to_mux); drives aw*, w*, ar*, bready, rready

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; awvalid=wvalid=arvalid=bready=rready=0; beat counter 0.
- Constant AXI fields:
  - len = BEATS-1, size = 3'b010, burst = 2'b01 (INCR)
  - lock, cache, prot, qos = 0
  - wstrb = 4'hF
  - id = AXI_ID
- Address: the request address is latched on the accept cycle, with its low log2(BEATS*4) bits forced to 0 (line aligned).
- Accept: req_valid && req_ready at an edge latches addr, write flag and wdata. req_ready is 1 only in IDLE.
- States:
  - IDLE: on accept, go to WADDR if req_write=1, otherwise RADDR.
  - RADDR: arvalid=1 and held; on arready go to RDATA.
  - RDATA: rready=1. Each rvalid beat stores rdata into word[cnt] and increments cnt. On the beat with cnt==BEATS-1, go to DONE.
  - WADDR: awvalid=1; on awready go to WDATA. W is never issued before the AW handshake.
  - WDATA: wvalid=1, wdata=word[cnt], wlast=(cnt==BEATS-1). On wready, increment cnt. On the last beat go to WRESP.
  - WRESP: bready=1; on bvalid go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE. cnt clears to 0.
- Latency with a zero-wait slave:
  - Read: accept → arvalid on the next cycle; resp_valid 2+BEATS cycles after accept.
  - Write: resp_valid 3+BEATS cycles after accept.
- AXI rules:
  - All valid signals and their payloads stay stable until the handshake completes.
  - No combinational path from any ready input to any valid output.
- Error flag: resp_err is set if any of the following occur during the transaction, and cleared on accept:
  - rresp != 0 or bresp != 0;
  - rlast=1 on a beat other than the last;
  - rlast=0 on the final beat.
- On error, the full burst is still consumed. No early exit.
- rid/bid are ignored; only one transaction is ever outstanding.
- A req_valid held during a busy period is not accepted until the cycle after DONE; no requests are lost.
- Reset mid-burst: every output returns to its reset value on the next edge and any partial data is discarded. The system resets the slave in the same event.
- Byte address of beat k = aligned_addr + 4k; wrap-around is not required, since lines never cross 4 KB.

Decomposition:
- common_types_pkg gains:
  - axi_burst_t (2'b01 INCR constant)
  - AXI_SIZE_WORD = 3'b010
  - AXI_RESP_OKAY = 2'b00
  - line_master_state_t enum (IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE)
- No sub-module: a single FSM plus the line register and counter.

Test Plan:
- Fill, zero-wait slave, req_addr=32'h1000_0044, BEATS=4:
  - araddr=32'h1000_0040, arlen=3;
  - R data 11,22,33,44 → resp_rdata=128'h00000044_00000033_00000022_00000011, resp_err=0, resp_valid 6 cycles after accept.
- Writeback to 32'h1000_0100 with wdata words A0..A3; slave holds awready low 3 cycles and drops wready on beat 2:
  - awvalid and awaddr stay stable through the stall;
  - exactly 4 W beats, wlast only on beat 3;
  - resp_valid one cycle after bvalid.
- Read where beat 1 has rresp=2'b10 → all 4 beats consumed, resp_err=1. An immediately following clean read → resp_err=0.
- Slave asserts rlast on beat 2 of 4 → resp_err=1, and the block still waits for beat 3.
- Back-to-back: req_valid held high with a write then a read → req_ready low while busy, the second request accepted the cycle after resp_valid, both complete correctly.
- Assert rst during WDATA beat 1 → next cycle wvalid=0, req_ready=1, resp_valid=0. A subsequent fill completes normally.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared AXI encodings and the line master state type.
// Imported by the manager-side bus blocks.
package common_types_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    LM_IDLE  = 3'd0,
    LM_RADDR = 3'd1,
    LM_RDATA = 3'd2,
    LM_WADDR = 3'd3,
    LM_WDATA = 3'd4,
    LM_WRESP = 3'd5,
    LM_DONE  = 3'd6
  } line_master_state_t;

  // Clears the low off_w address bits so a burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned off_w);
    logic [31:0] mask;
    mask = ~((32'd1 << off_w) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/axi_bus_if.sv
// AXI4 bundle between a manager and the AXI mux; 32-bit data, 4-bit IDs.
// The controller_to_mux modport is the manager view.
interface axi_bus_if;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport controller_to_mux (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport mux_to_controller (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_line_master.sv
// Turns single cache-line fill/writeback requests into AXI4 INCR bursts,
// one transaction outstanding at a time.
module axi_line_master
  import common_types_pkg::*;
#(
  parameter int         BEATS  = 4,
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         LINE_W = BEATS * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err,
  axi_bus_if.controller_to_mux abif
);

  localparam int               CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned      OFF_W    = $clog2(BEATS * 4);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  line_master_state_t state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [31:0]        addr_r, addr_s;
  logic [LINE_W-1:0]  line_r, line_s;
  logic               err_r, err_s;
  logic               last_beat_s;

  logic               req_ready_r;
  logic               resp_valid_r;
  logic               arvalid_r;
  logic               rready_r;
  logic               awvalid_r;
  logic               wvalid_r;
  logic               wlast_r;
  logic [31:0]        wdata_r;
  logic               bready_r;

  logic               unused_s;

  assign last_beat_s = (cnt_r == LAST_CNT);

  // Next-state, counter, line buffer and error accumulation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    line_s  = line_r;
    err_s   = err_r;
    case (state_r)
      LM_IDLE: begin
        if (req_valid) begin
          addr_s  = line_align(req_addr, OFF_W);
          line_s  = req_write ? req_wdata : {LINE_W{1'b0}};
          err_s   = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
          state_s = req_write ? LM_WADDR : LM_RADDR;
        end else begin
          state_s = LM_IDLE;
        end
      end
      LM_RADDR: begin
        if (abif.arready) begin
          state_s = LM_RDATA;
        end else begin
          state_s = LM_RADDR;
        end
      end
      LM_RDATA: begin
        if (abif.rvalid) begin
          line_s[32*int'(cnt_r) +: 32] = abif.rdata;
          cnt_s   = cnt_r + CNT_W'(1);
          // rlast must coincide exactly with the final beat; a bad burst is still drained.
          err_s   = err_r | (abif.rresp != AXI_RESP_OKAY) | (abif.rlast != last_beat_s);
          state_s = last_beat_s ? LM_DONE : LM_RDATA;
        end else begin
          state_s = LM_RDATA;
        end
      end
      LM_WADDR: begin
        if (abif.awready) begin
          state_s = LM_WDATA;
        end else begin
          state_s = LM_WADDR;
        end
      end
      LM_WDATA: begin
        if (abif.wready) begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = last_beat_s ? LM_WRESP : LM_WDATA;
        end else begin
          state_s = LM_WDATA;
        end
      end
      LM_WRESP: begin
        if (abif.bvalid) begin
          err_s   = err_r | (abif.bresp != AXI_RESP_OKAY);
          state_s = LM_DONE;
        end else begin
          state_s = LM_WRESP;
        end
      end
      LM_DONE: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = LM_IDLE;
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = LM_IDLE;
      end
    endcase
  end

  // State registers; bus controls are registered from the next state so no ready feeds a valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= LM_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      addr_r       <= 32'h0000_0000;
      line_r       <= {LINE_W{1'b0}};
      err_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      wlast_r      <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      bready_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      addr_r       <= addr_s;
      line_r       <= line_s;
      err_r        <= err_s;
      req_ready_r  <= (state_s == LM_IDLE);
      resp_valid_r <= (state_s == LM_DONE);
      arvalid_r    <= (state_s == LM_RADDR);
      rready_r     <= (state_s == LM_RDATA);
      awvalid_r    <= (state_s == LM_WADDR);
      wvalid_r     <= (state_s == LM_WDATA);
      wlast_r      <= (state_s == LM_WDATA) && (cnt_s == LAST_CNT);
      wdata_r      <= line_s[32*int'(cnt_s) +: 32];
      bready_r     <= (state_s == LM_WRESP);
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = line_r;
  assign resp_err   = err_r;

  assign abif.awid    = AXI_ID;
  assign abif.awaddr  = addr_r;
  assign abif.awlen   = 8'(BEATS - 1);
  assign abif.awsize  = AXI_SIZE_WORD;
  assign abif.awburst = AXI_BURST_INCR;
  assign abif.awlock  = 1'b0;
  assign abif.awcache = 4'h0;
  assign abif.awprot  = 3'h0;
  assign abif.awqos   = 4'h0;
  assign abif.awvalid = awvalid_r;

  assign abif.wdata   = wdata_r;
  assign abif.wstrb   = 4'hF;
  assign abif.wlast   = wlast_r;
  assign abif.wvalid  = wvalid_r;
  assign abif.bready  = bready_r;

  assign abif.arid    = AXI_ID;
  assign abif.araddr  = addr_r;
  assign abif.arlen   = 8'(BEATS - 1);
  assign abif.arsize  = AXI_SIZE_WORD;
  assign abif.arburst = AXI_BURST_INCR;
  assign abif.arlock  = 1'b0;
  assign abif.arcache = 4'h0;
  assign abif.arprot  = 3'h0;
  assign abif.arqos   = 4'h0;
  assign abif.arvalid = arvalid_r;
  assign abif.rready  = rready_r;

  // Response IDs carry no information with a single outstanding transaction.
  assign unused_s = ^{abif.rid, abif.bid};

endmodule
